// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and helpers for the FIFO write-port arbiter
// Purpose: arbiter state encoding, grant-index width helper and the
//          circular round-robin pick function used by rr_pick_comb.
// Ports:   none (package).
package fifo_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Widest requester vector the pick helper handles.
  localparam int MAX_REQ = 32;

  typedef struct packed {
    logic        found;
    logic [31:0] idx;
  } rr_pick_t;

  // Grant index width; a single requester still gets a 1-bit index.
  function automatic int gnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // First set bit of req scanning ptr, ptr+1, ... wrapping at n.
  // Offsets are walked from high to low so the smallest offset wins last.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input int ptr, input int n);
    rr_pick_t r;
    int       k;
    r = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (i < n) begin
        k = ptr + i;
        if (k >= n) k = k - n;
        if (req[k[4:0]]) begin
          r.found = 1'b1;
          r.idx   = k;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick_comb.sv
// rtl/rr_pick_comb.sv - combinational circular priority encoder
// Purpose: pick the first asserted request at or after the round-robin pointer.
// Ports:   i_req  - request vector (NUM_REQ)
//          i_ptr  - round-robin start index (GNT_W)
//          o_idx  - selected index (GNT_W), 0 when nothing requested
//          o_any  - at least one request asserted
module rr_pick_comb
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GNT_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [GNT_W-1:0]   i_ptr,
  output logic [GNT_W-1:0]   o_idx,
  output logic               o_any
);

  logic [MAX_REQ-1:0] w_req_ext;
  rr_pick_t           w_pick;

  always_comb begin
    w_req_ext                = '0;
    w_req_ext[NUM_REQ-1:0]   = i_req;
  end

  assign w_pick = rr_pick(w_req_ext, int'(i_ptr), NUM_REQ);
  assign o_idx  = GNT_W'(w_pick.idx);
  assign o_any  = w_pick.found;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - packet-aware round-robin arbiter for a FIFO write port
// Purpose: shares one FIFO write port among NUM_REQ requesters, holding the
//          grant for a whole packet (until an accepted beat with last set).
//          Optional macro FIFO_ARB_BURST_LIMIT_EN also releases the grant
//          after MAX_BURST accepted beats.
// Ports:   i_clk, i_rst      - write-domain clock, sync active-high reset
//          i_req_valid/last  - per-requester beat valid / end of packet
//          i_req_data        - packed beats, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//          o_req_ready       - per-requester beat accept
//          o_w_valid/o_w_data, i_w_ready - FIFO write port
//          o_gnt_id          - current grant holder, 0 when idle
//          o_busy            - grant held
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0]            i_req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_w_valid,
  output logic [DATA_WIDTH-1:0]         o_w_data,
  input  logic                          i_w_ready,
  output logic [gnt_w(NUM_REQ)-1:0]     o_gnt_id,
  output logic                          o_busy
);

  localparam int GNT_W = gnt_w(NUM_REQ);

  arb_state_t       r_state, w_state_nxt;
  logic [GNT_W-1:0] r_rr_ptr, r_gnt_id, w_pick_idx, w_ptr_nxt;
  logic             w_pick_any, w_accept, w_release, w_burst_hit;

  rr_pick_comb #(
    .NUM_REQ (NUM_REQ),
    .GNT_W   (GNT_W)
  ) u_pick (
    .i_req (i_req_valid),
    .i_ptr (r_rr_ptr),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  assign w_accept  = (r_state == LOCKED) & i_req_valid[r_gnt_id] & i_w_ready;
  assign w_release = w_accept & (i_req_last[r_gnt_id] | w_burst_hit);
  assign w_ptr_nxt = (r_gnt_id == GNT_W'(NUM_REQ - 1)) ? '0 : r_gnt_id + GNT_W'(1);

`ifdef FIFO_ARB_BURST_LIMIT_EN
  localparam int BCW = $clog2(MAX_BURST) + 1;

  logic [BCW-1:0] r_beat_cnt, w_cnt_inc;

  assign w_cnt_inc   = r_beat_cnt + BCW'(1);
  // Release on the beat that brings the count up to MAX_BURST.
  assign w_burst_hit = (w_cnt_inc == BCW'(MAX_BURST));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_beat_cnt <= '0;
    end else if (w_release) begin
      r_beat_cnt <= '0;
    end else if (w_accept) begin
      r_beat_cnt <= w_cnt_inc;
    end
  end
`else
  // Grants last until end of packet; MAX_BURST has no effect in this build.
  logic w_unused_max_burst;
  assign w_unused_max_burst = (MAX_BURST > 1);
  assign w_burst_hit        = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    o_req_ready = '0;
    o_w_valid   = 1'b0;
    o_w_data    = '0;
    case (r_state)
      IDLE: begin
        if (w_pick_any) w_state_nxt = LOCKED;
      end
      LOCKED: begin
        // Zero-latency passthrough from the grant holder to the FIFO.
        o_w_valid             = i_req_valid[r_gnt_id];
        o_w_data              = i_req_data[r_gnt_id*DATA_WIDTH +: DATA_WIDTH];
        o_req_ready[r_gnt_id] = i_w_ready;
        if (w_release) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_gnt_id <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_pick_any) begin
        r_gnt_id <= w_pick_idx;
      end else if (w_release) begin
        // gnt_id reads 0 whenever the arbiter is idle.
        r_gnt_id <= '0;
        r_rr_ptr <= w_ptr_nxt;
      end
    end
  end

  assign o_gnt_id = r_gnt_id;
  assign o_busy   = (r_state == LOCKED);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  localparam int NR   = 4;
  localparam int DW   = 8;
  localparam int MAXB = 8;

`ifdef FIFO_ARB_BURST_LIMIT_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid, req_last, req_ready;
  logic [NR*DW-1:0] req_data;
  logic             w_valid, w_ready, busy;
  logic [DW-1:0]    w_data;
  logic [1:0]       gnt_id;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MAXB)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .i_req_last  (req_last),
    .i_req_data  (req_data),
    .o_req_ready (req_ready),
    .o_w_valid   (w_valid),
    .o_w_data    (w_data),
    .i_w_ready   (w_ready),
    .o_gnt_id    (gnt_id),
    .o_busy      (busy)
  );

  // Requester drivers
  bit        d_valid[NR];
  bit        d_last[NR];
  logic [7:0] d_data[NR];
  int        rem[NR];
  int        seq[NR];
  bit        acc[NR];

  always_comb begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    for (int i = 0; i < NR; i++) begin
      req_valid[i]          = d_valid[i];
      req_last[i]           = d_last[i];
      req_data[i*DW +: DW]  = d_data[i];
    end
  end

  // Reference model: who holds the grant, and where the next search starts
  bit m_locked;
  int m_g, m_ptr, m_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [NR-1:0] exp_rdy;
    exp_rdy = '0;
    for (int i = 0; i < NR; i++) acc[i] = 1'b0;
    if (!m_locked) begin
      chk("busy", 32'(busy), 0);
      chk("gnt_id", 32'(gnt_id), 0);
      chk("w_valid", 32'(w_valid), 0);
      chk("w_data", 32'(w_data), 0);
      chk("req_ready", 32'(req_ready), 0);
    end else begin
      if (w_ready) exp_rdy[m_g] = 1'b1;
      chk("busy", 32'(busy), 1);
      chk("gnt_id", 32'(gnt_id), 32'(m_g));
      chk("w_valid", 32'(w_valid), 32'(d_valid[m_g]));
      chk("w_data", 32'(w_data), 32'(d_data[m_g]));
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      acc[m_g] = d_valid[m_g] & w_ready;
    end
  endtask

  task automatic advance_model(input bit r);
    if (r) begin
      m_locked = 0; m_g = 0; m_ptr = 0; m_cnt = 0;
    end else if (!m_locked) begin
      for (int off = 0; off < NR; off++) begin
        int k;
        k = (m_ptr + off) % NR;
        if (d_valid[k]) begin
          m_locked = 1; m_g = k; m_cnt = 0;
          break;
        end
      end
    end else if (acc[m_g]) begin
      m_cnt++;
      if (d_last[m_g] || (BURST_EN && m_cnt == MAXB)) begin
        m_locked = 0;
        m_ptr    = (m_g + 1) % NR;
        m_cnt    = 0;
      end
    end
  endtask

  task automatic drive_update(input bit was_rst);
    for (int i = 0; i < NR; i++) begin
      if (was_rst) begin
        d_valid[i] = 0; d_last[i] = 0; rem[i] = 0; acc[i] = 0;
        continue;
      end
      if (acc[i]) begin
        rem[i]--; seq[i]++; d_valid[i] = 0;
      end
      if (!d_valid[i]) begin
        if (rem[i] == 0) rem[i] = $urandom_range(1, 12);
        if ($urandom % 4 != 0) begin
          d_valid[i] = 1;
          d_data[i]  = 8'((i << 6) | (seq[i] & 63));
          d_last[i]  = (rem[i] == 1);
        end else begin
          d_last[i]  = 1'($urandom % 2);
          d_data[i]  = 8'($urandom);
        end
      end
    end
  endtask

  initial begin
    bit prev_rst;
    rst     = 1'b1;
    w_ready = 1'b1;
    for (int i = 0; i < NR; i++) begin
      d_valid[i] = 0; d_last[i] = 0; d_data[i] = '0; rem[i] = 0; seq[i] = 0; acc[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_w_valid", 32'(w_valid), 0);
      chk("idle_req_ready", 32'(req_ready), 0);
      chk("idle_gnt_id", 32'(gnt_id), 0);
      @(posedge clk);
      #1;
    end

    // Fairness: continuous 1-beat packets from everyone
    for (int i = 0; i < NR; i++) begin
      d_valid[i] = 1; d_last[i] = 1; d_data[i] = 8'(8'hC0 + i);
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("fair_busy", 32'(busy), 32'(k % 2));
      if (k % 2 == 1) begin
        chk("fair_gnt", 32'(gnt_id), 32'(((k - 1) / 2) % 4));
        chk("fair_data", 32'(w_data), 32'(8'hC0 + ((k - 1) / 2) % 4));
        chk("fair_ready", 32'(req_ready), 32'(1 << (((k - 1) / 2) % 4)));
      end
      @(posedge clk);
      #1;
    end

    // Re-synchronise with the model from a fresh reset
    for (int i = 0; i < NR; i++) begin
      d_valid[i] = 0; d_last[i] = 0; d_data[i] = '0;
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_locked = 0; m_g = 0; m_ptr = 0; m_cnt = 0;
    prev_rst = 1'b0;

    // Randomised traffic, FIFO backpressure and occasional mid-packet reset
    for (int cyc = 0; cyc < 4000; cyc++) begin
      drive_update(prev_rst);
      rst     = ($urandom_range(0, 399) == 0);
      w_ready = ($urandom % 4 != 0);
      @(negedge clk);
      check_model();
      @(posedge clk);
      advance_model(rst);
      prev_rst = rst;
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
